axi_lite_reg_slave: RTL and testbench

AXI-Lite responder terminating a master-side link: a bank of NUM_REGS software-visible DATA_WIDTH registers with byte-strobe writes and registered read data. It sits at the slave end of an axi_lite_if link, behind a bridge or directly on a master. It exposes the register contents and per-register write pulses to local logic. Port names match axi_lite_if fields so a wrapper binds them one-to-one.

---
 rtl/axi_lite_reg_slave_if.sv | 36 +++
 rtl/axi_lite_reg_slave.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite link between a master and a register-bank responder.
// Field names match the ports of axi_lite_reg_slave one-to-one.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank: NUM_REGS byte-strobed registers, registered read data,
// register contents and per-register write pulses exported to local logic.
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_reg_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic                           wr_state_dbg,
  output logic                           rd_state_dbg
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = ADDR_WIDTH - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both 1;
  // every valid/ready/data output here is a register and is held until that edge.
  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]            b_resp_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]      w_strb_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  ar_ready_q, r_valid_q;
  logic [1:0]            r_resp_q;
  logic [DATA_WIDTH-1:0] r_data_q;

  logic                  aw_hs, w_hs, aw_have, w_have, wr_ok, rd_ok;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_val;
  logic [BYTES-1:0]      wr_strb;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.aw_addr[LSB-1:0], bus.ar_addr[LSB-1:0]};

  // A channel counts as held if it handshakes now or was latched earlier
  // (in WR_COLLECT a low ready means that channel is already latched).
  always_comb begin
    aw_hs   = bus.aw_valid & aw_ready_q;
    w_hs    = bus.w_valid & w_ready_q;
    aw_have = aw_hs | ((wr_state == WR_COLLECT) & ~aw_ready_q);
    w_have  = w_hs  | ((wr_state == WR_COLLECT) & ~w_ready_q);
    wr_idx  = aw_hs ? bus.aw_addr[ADDR_WIDTH-1:LSB] : aw_idx_q;
    wr_data = w_hs ? bus.w_data : w_data_q;
    wr_strb = w_hs ? bus.w_strb : w_strb_q;
    wr_ok   = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
    rd_idx  = bus.ar_addr[ADDR_WIDTH-1:LSB];
    rd_ok   = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);
  end

  // Out-of-range indices match no register, so they read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state   <= WR_COLLECT;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (wr_state)
        WR_COLLECT: begin
          if (aw_hs) begin
            aw_idx_q   <= bus.aw_addr[ADDR_WIDTH-1:LSB];
            aw_ready_q <= 1'b0;
          end
          if (w_hs) begin
            w_data_q  <= bus.w_data;
            w_strb_q  <= bus.w_strb;
            w_ready_q <= 1'b0;
          end
          if (aw_have && w_have) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_ok && (wr_idx == IDX_W'(i))) begin
                for (int b = 0; b < BYTES; b++) begin
                  if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
                wr_pulse_q[i] <= 1'b1;
              end
            end
            b_resp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            b_valid_q  <= 1'b1;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            wr_state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wr_state   <= WR_COLLECT;
          end
        end
        default: wr_state <= WR_COLLECT;
      endcase
    end
  end

  // Reads sample regs before any same-edge write commit lands, returning the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (bus.ar_valid) begin
            r_data_q   <= rd_val;
            r_resp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            rd_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.r_ready) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rd_state   <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign bus.aw_ready  = aw_ready_q;
  assign bus.w_ready   = w_ready_q;
  assign bus.b_valid   = b_valid_q;
  assign bus.b_resp    = b_resp_q;
  assign bus.ar_ready  = ar_ready_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_resp    = r_resp_q;
  assign bus.r_data    = r_data_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_state_dbg  = wr_state;
  assign rd_state_dbg  = rd_state;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed cases from the test plan plus
// a short randomised mix, responses checked against a register model and expected queues.
module tb_axi_lite_reg_slave;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SB = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;
  logic             wr_state_dbg, rd_state_dbg;

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .reg_out      (reg_out),
    .wr_pulse     (wr_pulse),
    .wr_state_dbg (wr_state_dbg),
    .rd_state_dbg (rd_state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]   model [NR];
  logic [1:0]      b_exp_q[$];
  logic [NR-1:0]   p_exp_q[$];
  logic [DW+1:0]   r_exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s_reg%0d", tag, i), 64'(reg_out[i*DW +: DW]), 64'(model[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic push_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SB-1:0] strb);
    int idx;
    idx = int'(addr[AW-1:2]);
    if (idx < NR) begin
      for (int b = 0; b < SB; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      b_exp_q.push_back(2'b00);
      p_exp_q.push_back(NR'(1) << idx);
    end else begin
      b_exp_q.push_back(2'b10);
      p_exp_q.push_back('0);
    end
  endtask

  task automatic push_read(input logic [AW-1:0] addr);
    int idx;
    idx = int'(addr[AW-1:2]);
    if (idx < NR) r_exp_q.push_back({2'b00, model[idx]});
    else          r_exp_q.push_back({2'b10, {DW{1'b0}}});
  endtask

  // lead > 0: W goes lead cycles before AW; lead < 0: AW goes first; 0: same cycle.
  task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [SB-1:0] strb, input int lead);
    int n;
    n = (lead < 0) ? -lead : lead;
    bus.aw_addr = addr;
    bus.w_data  = data;
    bus.w_strb  = strb;
    if (lead == 0) begin
      check("aw_ready_idle", 64'(bus.aw_ready), 64'd1);
      check("w_ready_idle", 64'(bus.w_ready), 64'd1);
      bus.aw_valid = 1'b1;
      bus.w_valid  = 1'b1;
      tick();
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'b0;
    end else if (lead > 0) begin
      bus.w_valid = 1'b1;
      tick();
      bus.w_valid = 1'b0;
      for (int k = 0; k < n - 1; k++) begin
        check("w_ready_wait", 64'(bus.w_ready), 64'd0);
        check("b_valid_wait", 64'(bus.b_valid), 64'd0);
        tick();
      end
      check("w_ready_wait", 64'(bus.w_ready), 64'd0);
      bus.aw_valid = 1'b1;
      tick();
      bus.aw_valid = 1'b0;
    end else begin
      bus.aw_valid = 1'b1;
      tick();
      bus.aw_valid = 1'b0;
      for (int k = 0; k < n - 1; k++) begin
        check("aw_ready_wait", 64'(bus.aw_ready), 64'd0);
        check("b_valid_wait", 64'(bus.b_valid), 64'd0);
        tick();
      end
      check("aw_ready_wait", 64'(bus.aw_ready), 64'd0);
      bus.w_valid = 1'b1;
      tick();
      bus.w_valid = 1'b0;
    end
  endtask

  task automatic drive_read(input logic [AW-1:0] addr);
    bus.ar_addr  = addr;
    check("ar_ready_idle", 64'(bus.ar_ready), 64'd1);
    bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
  endtask

  task automatic finish_write(input int hold);
    int t;
    logic [1:0]    be;
    logic [NR-1:0] pe;
    t = 0;
    while (!bus.b_valid && t < 20) begin
      tick();
      t++;
    end
    check("b_latency", 64'(t), 64'd0);
    be = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : 2'bxx;
    pe = (p_exp_q.size() > 0) ? p_exp_q.pop_front() : 'x;
    check("b_resp", 64'(bus.b_resp), 64'(be));
    check("wr_pulse", 64'(wr_pulse), 64'(pe));
    check("aw_ready_resp", 64'(bus.aw_ready), 64'd0);
    check("w_ready_resp", 64'(bus.w_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("b_valid_hold", 64'(bus.b_valid), 64'd1);
      check("b_resp_hold", 64'(bus.b_resp), 64'(be));
      check("wr_pulse_once", 64'(wr_pulse), 64'd0);
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    check("b_valid_clear", 64'(bus.b_valid), 64'd0);
    check("wr_pulse_clear", 64'(wr_pulse), 64'd0);
    check("aw_ready_back", 64'(bus.aw_ready), 64'd1);
    check("w_ready_back", 64'(bus.w_ready), 64'd1);
    check_regs("after_wr");
  endtask

  task automatic finish_read(input int hold);
    int t;
    logic [DW+1:0] re;
    t = 0;
    while (!bus.r_valid && t < 20) begin
      tick();
      t++;
    end
    check("r_latency", 64'(t), 64'd0);
    re = (r_exp_q.size() > 0) ? r_exp_q.pop_front() : 'x;
    check("r_data", 64'(bus.r_data), 64'(re[DW-1:0]));
    check("r_resp", 64'(bus.r_resp), 64'(re[DW+1:DW]));
    check("ar_ready_busy", 64'(bus.ar_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("r_valid_hold", 64'(bus.r_valid), 64'd1);
      check("r_data_hold", 64'(bus.r_data), 64'(re[DW-1:0]));
      check("ar_ready_hold", 64'(bus.ar_ready), 64'd0);
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("r_valid_clear", 64'(bus.r_valid), 64'd0);
    check("ar_ready_back", 64'(bus.ar_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SB-1:0] s;
    int lead;

    bus.aw_addr = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0;  bus.w_strb = '0;  bus.w_valid = 1'b0;
    bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;
    model_reset();

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
    check("rst_w_ready", 64'(bus.w_ready), 64'd1);
    check("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_r_data", 64'(bus.r_data), 64'd0);
    check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check_regs("rst");
    tick();

    // Same-cycle AW/W full-word write
    push_write(8'h04, 32'hDEADBEEF, 4'hF);
    drive_write(8'h04, 32'hDEADBEEF, 4'hF, 0);
    finish_write(0);
    check("t1_reg1", 64'(reg_out[1*DW +: DW]), 64'hDEADBEEF);

    // W three cycles ahead of AW, partial strobe
    push_write(8'h04, 32'h11223344, 4'b0101);
    drive_write(8'h04, 32'h11223344, 4'b0101, 3);
    finish_write(0);
    check("t2_reg1", 64'(reg_out[1*DW +: DW]), 64'hDE22BE44);

    // Read with r_ready back-pressure
    push_read(8'h04);
    drive_read(8'h04);
    finish_read(5);

    // Out-of-range write and read
    push_write(8'h40, 32'hCAFEF00D, 4'hF);
    drive_write(8'h40, 32'hCAFEF00D, 4'hF, 0);
    finish_write(2);
    push_read(8'h40);
    drive_read(8'h40);
    finish_read(0);

    // Read and write commit to reg 2 on the same edge
    push_read(8'h08);
    push_write(8'h08, 32'h000000A5, 4'hF);
    bus.aw_addr = 8'h08; bus.w_data = 32'h000000A5; bus.w_strb = 4'hF; bus.ar_addr = 8'h08;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    finish_write(0);
    finish_read(0);
    push_read(8'h0A);
    drive_read(8'h0A);
    finish_read(1);

    // Randomised mix of writes (both orders, partial strobes) and reads
    for (int it = 0; it < 24; it++) begin
      a = {6'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        d    = $urandom();
        s    = SB'($urandom_range(0, (1 << SB) - 1));
        lead = int'($urandom_range(0, 6)) - 3;
        push_write(a, d, s);
        drive_write(a, d, s, lead);
        finish_write(int'($urandom_range(0, 2)));
      end else begin
        push_read(a);
        drive_read(a);
        finish_read(int'($urandom_range(0, 2)));
      end
    end

    // Reset while a write response is pending
    push_write(8'h0C, 32'h12345678, 4'hF);
    drive_write(8'h0C, 32'h12345678, 4'hF, 0);
    check("pre_rst_b_valid", 64'(bus.b_valid), 64'd1);
    check("pre_rst_reg3", 64'(reg_out[3*DW +: DW]), 64'h12345678);
    rst = 1'b1;
    #1;
    b_exp_q.delete();
    p_exp_q.delete();
    model_reset();
    check("mid_rst_b_valid", 64'(bus.b_valid), 64'd0);
    check_regs("mid_rst");
    tick();
    rst = 1'b0;
    check("post_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
    check("post_rst_w_ready", 64'(bus.w_ready), 64'd1);
    check("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);
    check("post_rst_r_valid", 64'(bus.r_valid), 64'd0);
    tick();
    push_read(8'h0C);
    drive_read(8'h0C);
    finish_read(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
